// File: rtl/comp_serie_nbit.sv
// Bit-serial unsigned magnitude comparator: operands arrive MSB-first, one bit pair per beat.
// The first differing bit pair decides the result; later pairs are only counted.
module comp_serie_nbit #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          a_bit,
  input  logic          b_bit,
  output logic          busy,
  output logic          done,
  output logic          eq,
  output logic          gt,
  output logic          lt,
  output logic [CW-1:0] bit_cnt
);

  if (N < 2) begin : g_bad_n
    $error("comp_serie_nbit: N must be at least 2");
  end
  if ((64'd1 << CW) <= 64'(N)) begin : g_bad_cw
    $error("comp_serie_nbit: CW too narrow to count N bit pairs");
  end

  localparam logic [CW-1:0] LastIdx = CW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          decided_q, decided_d;
  logic          gt_acc_q, gt_acc_d;
  logic          lt_acc_q, lt_acc_d;
  logic          eq_q, eq_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    gt_acc_d  = gt_acc_q;
    lt_acc_d  = lt_acc_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StShift;
          cnt_d     = '0;
          decided_d = 1'b0;
          gt_acc_d  = 1'b0;
          lt_acc_d  = 1'b0;
          // Hide the previous result while the new word is being shifted in.
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
        end
      end

      StShift: begin
        if (bit_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (!decided_q && (a_bit != b_bit)) begin
            decided_d = 1'b1;
            gt_acc_d  = a_bit;
            lt_acc_d  = b_bit;
          end
          // Publish on the last pair so the flags are already valid in the done cycle.
          if (cnt_q == LastIdx) begin
            state_d = StDone;
            eq_d    = ~decided_d;
            gt_d    = gt_acc_d;
            lt_d    = lt_acc_d;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_acc_q  <= 1'b0;
      lt_acc_q  <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      gt_acc_q  <= gt_acc_d;
      lt_acc_q  <= lt_acc_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign busy    = (state_q == StShift);
  assign done    = (state_q == StDone);
  assign eq      = eq_q;
  assign gt      = gt_q;
  assign lt      = lt_q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_comp_serie_nbit.sv
// Directed bench for comp_serie_nbit: vector table of operand pairs plus hand-written
// sequences for stalls, mid-word reset and ignored start/bit_valid.
module tb_comp_serie_nbit;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          bit_valid;
  logic          a_bit;
  logic          b_bit;
  logic          busy;
  logic          done;
  logic          eq;
  logic          gt;
  logic          lt;
  logic [CW-1:0] bit_cnt;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       e;
    logic       g;
    logic       l;
  } vec_t;

  vec_t vecs[6];

  comp_serie_nbit #(
    .N (N),
    .CW(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bit_valid(bit_valid),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .busy     (busy),
    .done     (done),
    .eq       (eq),
    .gt       (gt),
    .lt       (lt),
    .bit_cnt  (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams one word MSB-first. gap_at1/gap_at2 insert gap_len idle beats after that many
  // accepted pairs; restart_at pulses start together with that bit index (and in DONE).
  task automatic run_word(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic e, input logic g, input logic l,
                          input int gap_at1, input int gap_at2, input int gap_len,
                          input int restart_at);
    int k;
    int extra;
    k     = 0;
    extra = 0;
    // A bit pair offered in the start cycle must not be taken (it would read as A>B).
    start     = 1'b1;
    bit_valid = 1'b1;
    a_bit     = 1'b1;
    b_bit     = 1'b0;
    step();
    start     = 1'b0;
    bit_valid = 1'b0;
    check({tag, " enter busy"}, 32'(busy), 32'd1);
    check({tag, " enter cnt"}, 32'(bit_cnt), 32'd0);
    check({tag, " enter flags"}, 32'({eq, gt, lt}), 32'd0);
    check({tag, " enter done"}, 32'(done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      a_bit     = a[7-i];
      b_bit     = b[7-i];
      bit_valid = 1'b1;
      start     = (i == restart_at);
      step();
      k++;
      start     = 1'b0;
      bit_valid = 1'b0;
      if (i < 7) begin
        check($sformatf("%s bit%0d busy", tag, i), 32'(busy), 32'd1);
        check($sformatf("%s bit%0d cnt", tag, i), 32'(bit_cnt), 32'(i + 1));
        check($sformatf("%s bit%0d flags", tag, i), 32'({done, eq, gt, lt}), 32'd0);
      end
      if ((i + 1 == gap_at1) || (i + 1 == gap_at2)) begin
        for (int j = 0; j < gap_len; j++) begin
          a_bit = ~a_bit;
          b_bit = ~b_bit;
          step();
          k++;
          extra++;
          check($sformatf("%s gap%0d busy", tag, i), 32'(busy), 32'd1);
          check($sformatf("%s gap%0d cnt", tag, i), 32'(bit_cnt), 32'(i + 1));
        end
      end
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " done busy"}, 32'(busy), 32'd0);
    check({tag, " done cnt"}, 32'(bit_cnt), 32'd8);
    check({tag, " eq/gt/lt"}, 32'({eq, gt, lt}), 32'({e, g, l}));
    check({tag, " latency"}, 32'(k + 1), 32'(9 + extra));
    start = (restart_at >= 0);
    step();
    start = 1'b0;
    check({tag, " after done"}, 32'(done), 32'd0);
    check({tag, " after busy"}, 32'(busy), 32'd0);
    check({tag, " hold flags"}, 32'({eq, gt, lt}), 32'({e, g, l}));
    check({tag, " hold cnt"}, 32'(bit_cnt), 32'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 8'hA5, b: 8'hA5, e: 1'b1, g: 1'b0, l: 1'b0};
    vecs[1] = '{a: 8'h80, b: 8'h7F, e: 1'b0, g: 1'b1, l: 1'b0};
    vecs[2] = '{a: 8'h3C, b: 8'h3D, e: 1'b0, g: 1'b0, l: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'hFF, e: 1'b0, g: 1'b0, l: 1'b1};
    vecs[4] = '{a: 8'hFF, b: 8'hFE, e: 1'b0, g: 1'b1, l: 1'b0};
    vecs[5] = '{a: 8'h6B, b: 8'h2B, e: 1'b0, g: 1'b1, l: 1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    bit_valid = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    step();
    step();
    check("reset outputs", 32'({busy, done, eq, gt, lt, bit_cnt}), 32'd0);
    reset = 1'b0;
    step();
    check("idle after reset", 32'({busy, done, eq, gt, lt, bit_cnt}), 32'd0);

    for (int v = 0; v < 6; v++) begin
      run_word($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].e, vecs[v].g,
               vecs[v].l, -1, -1, 0, -1);
    end

    // Stalls after pairs 2 and 5 stretch the word by 6 cycles.
    run_word("stall", 8'h55, 8'h54, 1'b0, 1'b1, 1'b0, 2, 5, 3, -1);

    // Mid-word reset: partial A=F0/B=0F is dropped, no done pulse.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_bit     = 1'b1;
      b_bit     = 1'b0;
      bit_valid = 1'b1;
      step();
    end
    bit_valid = 1'b0;
    check("pre-reset cnt", 32'(bit_cnt), 32'd4);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async reset outputs", 32'({busy, done, eq, gt, lt, bit_cnt}), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post-reset idle%0d", i), 32'({busy, done, eq, gt, lt, bit_cnt}),
            32'd0);
    end
    run_word("zero", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, -1, -1, 0, -1);

    // bit_valid while idle must not count or disturb the held result.
    bit_valid = 1'b1;
    a_bit     = 1'b0;
    b_bit     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle valid%0d", i), 32'({busy, done, bit_cnt}), 32'(8));
      check($sformatf("idle flags%0d", i), 32'({eq, gt, lt}), 32'(3'b100));
    end
    bit_valid = 1'b0;
    run_word("restart", 8'hC3, 8'hC7, 1'b0, 1'b0, 1'b1, -1, -1, 0, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
